// File: rtl/iterative_alu_if.sv
// Operand/result bundle for iterative_alu: the requester drives start and operands,
// and the ALU returns busy, the done pulse and the registered result.
interface iterative_alu_if;
  logic        start_i;
  logic [3:0]  alu_ctrl_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;

  modport master (
    output start_i, alu_ctrl_i, src_a_i, src_b_i,
    input  busy_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, alu_ctrl_i, src_a_i, src_b_i,
    output busy_o, done_o, result_o, zero_o
  );
endinterface

// File: rtl/iterative_alu.sv
// 32-bit ALU with a one-bit-per-cycle shifter; defining ITERATIVE_ALU_FAST_SHIFT_EN
// replaces the iterative shifter with a single-cycle barrel shifter.
module iterative_alu (
  input  logic           clk_i,
  input  logic           rst_i,
  iterative_alu_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] work_reg, work_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [3:0]  op_reg, op_next;
  logic [31:0] result_reg, result_next;
  logic        zero_reg, zero_next;

  logic [4:0]  shamt;
  logic        accept;
  logic        go_iter;
  logic [31:0] alu_result;
  logic [31:0] shift_step;

  assign shamt  = bus.src_b_i[4:0];
  assign accept = bus.start_i && ((state_reg == IDLE) || (state_reg == DONE));

`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
  assign go_iter     = 1'b0;
  assign bus.busy_o  = 1'b0;
`else
  logic is_shift_op;
  assign is_shift_op = (bus.alu_ctrl_i == OP_SLL) || (bus.alu_ctrl_i == OP_SRL) ||
                       (bus.alu_ctrl_i == OP_SRA);
  assign go_iter     = is_shift_op && (shamt != 5'd0);
  assign bus.busy_o  = (state_reg == SHIFT);
`endif

  assign bus.done_o   = (state_reg == DONE);
  assign bus.result_o = result_reg;
  assign bus.zero_o   = zero_reg;

  // Single-cycle result; in iterative mode shifts only land here when shamt is 0.
  always_comb begin
    alu_result = 32'd0;
    case (bus.alu_ctrl_i)
      OP_ADD:  alu_result = bus.src_a_i + bus.src_b_i;
      OP_SUB:  alu_result = bus.src_a_i - bus.src_b_i;
      OP_AND:  alu_result = bus.src_a_i & bus.src_b_i;
      OP_OR:   alu_result = bus.src_a_i | bus.src_b_i;
      OP_XOR:  alu_result = bus.src_a_i ^ bus.src_b_i;
      OP_SLT:  alu_result = {31'd0, $signed(bus.src_a_i) < $signed(bus.src_b_i)};
      OP_SLTU: alu_result = {31'd0, bus.src_a_i < bus.src_b_i};
`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
      OP_SLL:  alu_result = bus.src_a_i << shamt;
      OP_SRL:  alu_result = bus.src_a_i >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(bus.src_a_i) >>> shamt);
`else
      OP_SLL, OP_SRL, OP_SRA: alu_result = bus.src_a_i;
`endif
      default: alu_result = 32'd0;
    endcase
  end

  // SRA keeps replicating bit 31, which never changes during the shift.
  always_comb begin
    case (op_reg)
      OP_SLL:  shift_step = {work_reg[30:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, work_reg[31:1]};
      default: shift_step = {work_reg[31], work_reg[31:1]};
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          if (go_iter) begin
            state_next = SHIFT;
            work_next  = bus.src_a_i;
            cnt_next   = shamt;
            op_next    = bus.alu_ctrl_i;
          end else begin
            state_next  = DONE;
            result_next = alu_result;
            zero_next   = (alu_result == 32'd0);
          end
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        work_next = shift_step;
        cnt_next  = cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) begin
          state_next  = DONE;
          result_next = shift_step;
          zero_next   = (shift_step == 32'd0);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      work_reg   <= 32'd0;
      cnt_reg    <= 5'd0;
      op_reg     <= 4'd0;
      result_reg <= 32'd0;
      zero_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Randomized and directed checks of iterative_alu against an arithmetic reference model;
// honours ITERATIVE_ALU_FAST_SHIFT_EN for expected latencies.
module tb_iterative_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  iterative_alu_if alu_bus ();

  iterative_alu dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (alu_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && (b % 32) != 0) return 1 + int'(b % 32);
    return 1;
`endif
  endfunction

  // Issue one op starting in the current cycle; poke_at > 0 re-pulses start mid-op.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int poke_at);
    logic [31:0] exp;
    int lat;
    int k;
    exp = ref_alu(op, a, b);
    lat = ref_lat(op, b);
    alu_bus.alu_ctrl_i = op;
    alu_bus.src_a_i    = a;
    alu_bus.src_b_i    = b;
    alu_bus.start_i    = 1'b1;
    @(posedge clk); #1;
    alu_bus.start_i = 1'b0;
    k = 1;
    while (!alu_bus.done_o && k < 40) begin
      check({name, "_busy"}, {31'd0, alu_bus.busy_o}, {31'd0, k < lat});
      if (k == poke_at) begin
        alu_bus.start_i    = 1'b1;
        alu_bus.alu_ctrl_i = 4'd0;
        alu_bus.src_a_i    = 32'h1234_5678;
        alu_bus.src_b_i    = 32'h0000_0001;
      end else begin
        alu_bus.start_i = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    alu_bus.start_i = 1'b0;
    check({name, "_latency"}, k, lat);
    check({name, "_done"}, {31'd0, alu_bus.done_o}, 32'd1);
    check({name, "_busy_at_done"}, {31'd0, alu_bus.busy_o}, 32'd0);
    check({name, "_result"}, alu_bus.result_o, exp);
    check({name, "_zero"}, {31'd0, alu_bus.zero_o}, {31'd0, exp == 32'd0});
    $display("op %s ctrl=%0d a=0x%08h b=0x%08h -> result=0x%08h zero=%0b cycles=%0d",
             name, op, a, b, alu_bus.result_o, alu_bus.zero_o, k);
    @(posedge clk); #1;
    check({name, "_done_clear"}, {31'd0, alu_bus.done_o}, 32'd0);
    check({name, "_hold"}, alu_bus.result_o, exp);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    alu_bus.start_i    = 1'b0;
    alu_bus.alu_ctrl_i = 4'd0;
    alu_bus.src_a_i    = 32'd0;
    alu_bus.src_b_i    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_done", {31'd0, alu_bus.done_o}, 32'd0);
    check("rst_busy", {31'd0, alu_bus.busy_o}, 32'd0);
    check("rst_result", alu_bus.result_o, 32'd0);
    check("rst_zero", {31'd0, alu_bus.zero_o}, 32'd1);

    run_op("add", 4'd0, 32'd5, 32'd7, 0);
    run_op("sub", 4'd1, 32'd3, 32'd3, 0);
    run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sra", 4'd9, 32'h8000_0000, 32'h0000_0104, 0);
    run_op("sll31_poke", 4'd7, 32'd1, 32'd31, 10);
    run_op("sll0", 4'd7, 32'hDEAD_BEEF, 32'h0000_0020, 0);
    run_op("undef", 4'hC, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 0);

    // Reset mid-shift, with start raised in the same cycle as reset.
    alu_bus.alu_ctrl_i = 4'd8;
    alu_bus.src_a_i    = 32'hFFFF_FFFF;
    alu_bus.src_b_i    = 32'd16;
    alu_bus.start_i    = 1'b1;
    @(posedge clk); #1;
    alu_bus.start_i = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst                = 1'b1;
    alu_bus.start_i    = 1'b1;
    alu_bus.alu_ctrl_i = 4'd0;
    alu_bus.src_a_i    = 32'd9;
    alu_bus.src_b_i    = 32'd9;
    @(posedge clk); #1;
    rst             = 1'b0;
    alu_bus.start_i = 1'b0;
    check("abort_done", {31'd0, alu_bus.done_o}, 32'd0);
    check("abort_busy", {31'd0, alu_bus.busy_o}, 32'd0);
    check("abort_result", alu_bus.result_o, 32'd0);
    check("abort_zero", {31'd0, alu_bus.zero_o}, 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (alu_bus.done_o) seen++;
      end
      check("abort_no_done", seen, 0);
    end
    $display("op reset_abort srl a=0xffffffff shamt=16 -> result=0x%08h zero=%0b",
             alu_bus.result_o, alu_bus.zero_o);

    // start held high across DONE: OR then XOR back-to-back.
    alu_bus.alu_ctrl_i = 4'd3;
    alu_bus.src_a_i    = 32'hF0;
    alu_bus.src_b_i    = 32'h0F;
    alu_bus.start_i    = 1'b1;
    @(posedge clk); #1;
    check("b2b_or_done", {31'd0, alu_bus.done_o}, 32'd1);
    check("b2b_or_result", alu_bus.result_o, 32'hFF);
    check("b2b_or_zero", {31'd0, alu_bus.zero_o}, 32'd0);
    alu_bus.alu_ctrl_i = 4'd4;
    alu_bus.src_a_i    = 32'hFF;
    alu_bus.src_b_i    = 32'hFF;
    @(posedge clk); #1;
    alu_bus.start_i = 1'b0;
    check("b2b_xor_done", {31'd0, alu_bus.done_o}, 32'd1);
    check("b2b_xor_result", alu_bus.result_o, 32'd0);
    check("b2b_xor_zero", {31'd0, alu_bus.zero_o}, 32'd1);
    @(posedge clk); #1;
    check("b2b_idle", {31'd0, alu_bus.done_o}, 32'd0);
    $display("op back_to_back or/xor -> result=0x%08h zero=%0b", alu_bus.result_o, alu_bus.zero_o);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 3 == 0) a = 32'h8000_0000 | a;
      if (i % 4 == 0) b = {27'($urandom), 5'($urandom_range(0, 6))};
      run_op("rand", op, a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
